// File: rtl/v_uesprit_acc_ctrl.sv
// v_uesprit_acc_ctrl
//   Sequencing controller in front of the U-ESPRIT correlation datapath.
//   - Frames the channelised sample stream into integrations of acc_len
//     spectra and issues dsp_new_acc on the first sample of each integration.
//   - Per-integration AGC on the correlation shift from the r11/r22 peaks.
//   - Captures eigen results into a valid/ready holding register.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   enable                run control (low -> IDLE, clears sync_err)
//   acc_len               spectra per integration (0 behaves as 1)
//   agc_en, shift_manual  AGC select / manual shift
//   thr_hi, thr_lo        AGC thresholds (unsigned compare against peak)
//   sync_in, din_valid    spectrum start (qualified by din_valid), sample valid
//   din{1,2}_{re,im}      input samples
//   dsp_din*, dsp_din_valid, dsp_new_acc, shift   registered datapath feed
//   r11, r22, corr_valid  correlation monitor
//   lamb1..eigen_x, dout_valid   eigen results from the datapath
//   res_*, res_tag, res_valid, res_ready   readout holding register
//   overrun_cnt           saturating count of dropped results
//   sync_err              sticky misaligned-sync flag
//   fsm_state             debug view of the sequencer: 0 IDLE, 1 ARM, 2 RUN
//
// Readout handshake: a result transfers on any cycle where res_valid and
// res_ready are both high. res_valid stays high until that transfer. A new
// dout_valid is accepted when the register is empty or is transferring in the
// same cycle; otherwise the new result is dropped and counted as an overrun.
//
// VECTOR_LEN must be a power of two and at least 2.
module v_uesprit_acc_ctrl #(
    parameter int VECTOR_LEN  = 512,
    parameter int ACC_WIDTH   = 8,
    parameter int SHIFT_WIDTH = 5,
    parameter int SHIFT_MAX   = 31,
    parameter int SHIFT_INIT  = 8,
    parameter int CORR_WIDTH  = 16,
    parameter int DOUT_WIDTH  = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          enable,
    input  logic [ACC_WIDTH-1:0]          acc_len,
    input  logic                          agc_en,
    input  logic [SHIFT_WIDTH-1:0]        shift_manual,
    input  logic [CORR_WIDTH-1:0]         thr_hi,
    input  logic [CORR_WIDTH-1:0]         thr_lo,
    input  logic                          sync_in,
    input  logic                          din_valid,
    input  logic signed [17:0]            din1_re,
    input  logic signed [17:0]            din1_im,
    input  logic signed [17:0]            din2_re,
    input  logic signed [17:0]            din2_im,
    output logic [17:0]                   dsp_din1_re,
    output logic [17:0]                   dsp_din1_im,
    output logic [17:0]                   dsp_din2_re,
    output logic [17:0]                   dsp_din2_im,
    output logic                          dsp_din_valid,
    output logic                          dsp_new_acc,
    output logic [SHIFT_WIDTH-1:0]        shift,
    input  logic signed [CORR_WIDTH-1:0]  r11,
    input  logic signed [CORR_WIDTH-1:0]  r22,
    input  logic                          corr_valid,
    input  logic [DOUT_WIDTH-1:0]         lamb1,
    input  logic [DOUT_WIDTH-1:0]         lamb2,
    input  logic [DOUT_WIDTH-1:0]         eigen1_y,
    input  logic [DOUT_WIDTH-1:0]         eigen2_y,
    input  logic [DOUT_WIDTH-1:0]         eigen_x,
    input  logic                          dout_valid,
    output logic [DOUT_WIDTH-1:0]         res_lamb1,
    output logic [DOUT_WIDTH-1:0]         res_lamb2,
    output logic [DOUT_WIDTH-1:0]         res_eigen1_y,
    output logic [DOUT_WIDTH-1:0]         res_eigen2_y,
    output logic [DOUT_WIDTH-1:0]         res_eigen_x,
    output logic [15:0]                   res_tag,
    output logic                          res_valid,
    input  logic                          res_ready,
    output logic [15:0]                   overrun_cnt,
    output logic                          sync_err,
    output logic [1:0]                    fsm_state
);

    localparam int CHAN_W = (VECTOR_LEN > 1) ? $clog2(VECTOR_LEN) : 1;
    localparam logic [CHAN_W-1:0] CHAN_LAST = CHAN_W'(VECTOR_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARM  = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    state_t                 state;
    // chan_cnt holds the channel index of the next sample to be forwarded.
    logic [CHAN_W-1:0]      chan_cnt;
    logic [ACC_WIDTH-1:0]   frame_cnt;
    logic [ACC_WIDTH-1:0]   frame_last;
    logic [15:0]            int_cnt;
    logic [CORR_WIDTH-1:0]  peak;
    logic                   seen;

    logic                   fwd_arm, fwd_run, fwd, misalign, first;
    logic [ACC_WIDTH-1:0]   frame_last_in;
    logic [CORR_WIDTH-1:0]  r11_pos, r22_pos, corr_max;
    logic                   res_load;

    always_comb begin
        fwd_arm  = (state == S_ARM) && enable && sync_in && din_valid;
        misalign = (state == S_RUN) && enable && din_valid && sync_in && (chan_cnt != '0);
        fwd_run  = (state == S_RUN) && enable && din_valid && !misalign;
        fwd      = fwd_arm || fwd_run;
        first    = fwd_arm || (fwd_run && (chan_cnt == '0) && (frame_cnt == '0));
        frame_last_in = (acc_len == '0) ? '0 : acc_len - ACC_WIDTH'(1);
    end

    assign fsm_state = state;

    // Sequencer: framing, sample forwarding and the new-accumulation strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            chan_cnt      <= '0;
            frame_cnt     <= '0;
            frame_last    <= '0;
            dsp_din1_re   <= '0;
            dsp_din1_im   <= '0;
            dsp_din2_re   <= '0;
            dsp_din2_im   <= '0;
            dsp_din_valid <= 1'b0;
            dsp_new_acc   <= 1'b0;
            sync_err      <= 1'b0;
        end else begin
            dsp_din_valid <= fwd;
            dsp_new_acc   <= first;
            if (fwd) begin
                dsp_din1_re <= din1_re;
                dsp_din1_im <= din1_im;
                dsp_din2_re <= din2_re;
                dsp_din2_im <= din2_im;
            end
            if (!enable) begin
                state     <= S_IDLE;
                chan_cnt  <= '0;
                frame_cnt <= '0;
                sync_err  <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        chan_cnt  <= '0;
                        frame_cnt <= '0;
                        state     <= S_ARM;
                    end
                    S_ARM: begin
                        if (fwd_arm) begin
                            // The sync sample itself is channel 0 of frame 0.
                            chan_cnt   <= CHAN_W'(1);
                            frame_cnt  <= '0;
                            frame_last <= frame_last_in;
                            state      <= S_RUN;
                        end
                    end
                    S_RUN: begin
                        if (misalign) begin
                            sync_err <= 1'b1;
                            state    <= S_ARM;
                        end else if (fwd_run) begin
                            chan_cnt <= chan_cnt + CHAN_W'(1);
                            if (chan_cnt == CHAN_LAST) begin
                                if (frame_cnt == frame_last) begin
                                    frame_cnt  <= '0;
                                    frame_last <= frame_last_in;
                                end else begin
                                    frame_cnt <= frame_cnt + ACC_WIDTH'(1);
                                end
                            end
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    // Negative correlations contribute nothing to the peak.
    always_comb begin
        r11_pos  = r11[CORR_WIDTH-1] ? '0 : r11;
        r22_pos  = r22[CORR_WIDTH-1] ? '0 : r22;
        corr_max = (r11_pos > r22_pos) ? r11_pos : r22_pos;
    end

    // AGC and integration counter. Both act on the edge that closes a
    // dsp_new_acc cycle, judging the peak gathered over the previous
    // integration; a corr_valid in that same cycle seeds the new peak.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift   <= SHIFT_WIDTH'(SHIFT_INIT);
            int_cnt <= '0;
            peak    <= '0;
            seen    <= 1'b0;
        end else if (dsp_new_acc) begin
            int_cnt <= int_cnt + 16'd1;
            if (!agc_en) begin
                shift <= shift_manual;
            end else if (seen) begin
                if ((peak >= thr_hi) && (shift < SHIFT_WIDTH'(SHIFT_MAX))) begin
                    shift <= shift + SHIFT_WIDTH'(1);
                end else if ((peak < thr_lo) && (shift != '0)) begin
                    shift <= shift - SHIFT_WIDTH'(1);
                end
            end
            peak <= corr_valid ? corr_max : '0;
            seen <= corr_valid;
        end else if (corr_valid) begin
            if (corr_max > peak) begin
                peak <= corr_max;
            end
            seen <= 1'b1;
        end
    end

    assign res_load = dout_valid && (!res_valid || res_ready);

    // Result holding register and overrun counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_lamb1    <= '0;
            res_lamb2    <= '0;
            res_eigen1_y <= '0;
            res_eigen2_y <= '0;
            res_eigen_x  <= '0;
            res_tag      <= '0;
            res_valid    <= 1'b0;
            overrun_cnt  <= '0;
        end else if (res_load) begin
            res_lamb1    <= lamb1;
            res_lamb2    <= lamb2;
            res_eigen1_y <= eigen1_y;
            res_eigen2_y <= eigen2_y;
            res_eigen_x  <= eigen_x;
            res_tag      <= int_cnt;
            res_valid    <= 1'b1;
        end else if (dout_valid) begin
            if (overrun_cnt != 16'hFFFF) begin
                overrun_cnt <= overrun_cnt + 16'd1;
            end
        end else if (res_ready) begin
            res_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_v_uesprit_acc_ctrl.sv
// Self-checking bench for v_uesprit_acc_ctrl (VECTOR_LEN = 8).
// A sample-position reference model predicts every registered output each
// cycle; directed sections add explicit checks for framing, sync errors, AGC
// and result capture, followed by a randomized soak with a mid-run reset.
module tb_v_uesprit_acc_ctrl;

    localparam int VL = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic               enable, agc_en, sync_in, din_valid, corr_valid, dout_valid, res_ready;
    logic [7:0]         acc_len;
    logic [4:0]         shift_manual;
    logic [15:0]        thr_hi, thr_lo;
    logic signed [17:0] din1_re, din1_im, din2_re, din2_im;
    logic signed [15:0] r11, r22;
    logic [15:0]        lamb1, lamb2, eigen1_y, eigen2_y, eigen_x;

    logic [17:0] dsp_din1_re, dsp_din1_im, dsp_din2_re, dsp_din2_im;
    logic        dsp_din_valid, dsp_new_acc, res_valid, sync_err;
    logic [4:0]  shift;
    logic [15:0] res_lamb1, res_lamb2, res_eigen1_y, res_eigen2_y, res_eigen_x;
    logic [15:0] res_tag, overrun_cnt;
    logic [1:0]  fsm_state;

    v_uesprit_acc_ctrl #(.VECTOR_LEN(VL)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .acc_len(acc_len),
        .agc_en(agc_en), .shift_manual(shift_manual), .thr_hi(thr_hi), .thr_lo(thr_lo),
        .sync_in(sync_in), .din_valid(din_valid),
        .din1_re(din1_re), .din1_im(din1_im), .din2_re(din2_re), .din2_im(din2_im),
        .dsp_din1_re(dsp_din1_re), .dsp_din1_im(dsp_din1_im),
        .dsp_din2_re(dsp_din2_re), .dsp_din2_im(dsp_din2_im),
        .dsp_din_valid(dsp_din_valid), .dsp_new_acc(dsp_new_acc), .shift(shift),
        .r11(r11), .r22(r22), .corr_valid(corr_valid),
        .lamb1(lamb1), .lamb2(lamb2), .eigen1_y(eigen1_y), .eigen2_y(eigen2_y),
        .eigen_x(eigen_x), .dout_valid(dout_valid),
        .res_lamb1(res_lamb1), .res_lamb2(res_lamb2), .res_eigen1_y(res_eigen1_y),
        .res_eigen2_y(res_eigen2_y), .res_eigen_x(res_eigen_x), .res_tag(res_tag),
        .res_valid(res_valid), .res_ready(res_ready), .overrun_cnt(overrun_cnt),
        .sync_err(sync_err), .fsm_state(fsm_state)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // m_mode: 0 idle, 1 armed, 2 running. m_pos is the position of the next
    // sample inside the current integration of m_len samples.
    int          m_mode, m_pos, m_len, m_int, m_peak;
    bit          m_seen;
    logic        e_dv, e_new, e_serr, e_rv;
    logic [17:0] e_d [4];
    logic [4:0]  e_shift;
    logic [15:0] e_res [5];
    logic [15:0] e_tag, e_ovr;

    function automatic int int_len(input logic [7:0] a);
        return VL * ((a == 8'd0) ? 1 : int'(a));
    endfunction

    task automatic model_reset();
        m_mode = 0; m_pos = 0; m_len = VL; m_int = 0; m_peak = 0; m_seen = 0;
        e_dv = 0; e_new = 0; e_serr = 0; e_rv = 0;
        for (int i = 0; i < 4; i++) e_d[i] = '0;
        for (int i = 0; i < 5; i++) e_res[i] = '0;
        e_shift = 5'd8; e_tag = '0; e_ovr = '0;
    endtask

    task automatic forward();
        e_dv = 1;
        e_d[0] = din1_re; e_d[1] = din1_im; e_d[2] = din2_re; e_d[3] = din2_im;
    endtask

    task automatic model_step();
        int pk;
        // result capture uses the integration count before this edge
        if (dout_valid && (!e_rv || res_ready)) begin
            e_res[0] = lamb1; e_res[1] = lamb2; e_res[2] = eigen1_y;
            e_res[3] = eigen2_y; e_res[4] = eigen_x;
            e_tag = 16'(m_int); e_rv = 1;
        end else if (dout_valid) begin
            if (e_ovr != 16'hFFFF) e_ovr = e_ovr + 16'd1;
        end else if (res_ready) begin
            e_rv = 0;
        end
        // AGC
        pk = 0;
        if (int'(r11) > pk) pk = int'(r11);
        if (int'(r22) > pk) pk = int'(r22);
        if (e_new) begin
            if (!agc_en) e_shift = shift_manual;
            else if (m_seen) begin
                if (m_peak >= int'(thr_hi) && e_shift < 5'd31) e_shift = e_shift + 5'd1;
                else if (m_peak < int'(thr_lo) && e_shift > 5'd0) e_shift = e_shift - 5'd1;
            end
            m_int = (m_int + 1) % 65536;
            m_peak = corr_valid ? pk : 0;
            m_seen = corr_valid;
        end else if (corr_valid) begin
            if (pk > m_peak) m_peak = pk;
            m_seen = 1;
        end
        // framing
        e_dv = 0; e_new = 0;
        if (!enable) begin
            m_mode = 0; e_serr = 0;
        end else if (m_mode == 0) begin
            m_mode = 1;
        end else if (m_mode == 1) begin
            if (sync_in && din_valid) begin
                forward(); e_new = 1;
                m_len = int_len(acc_len); m_pos = 1; m_mode = 2;
            end
        end else if (din_valid) begin
            if (sync_in && (m_pos % VL) != 0) begin
                e_serr = 1; m_mode = 1;
            end else begin
                forward(); e_new = (m_pos == 0);
                if (m_pos == m_len - 1) begin
                    m_pos = 0; m_len = int_len(acc_len);
                end else m_pos++;
            end
        end
    endtask

    task automatic compare_all();
        check("state", fsm_state, m_mode);
        check("dsp_din_valid", dsp_din_valid, e_dv);
        check("dsp_new_acc", dsp_new_acc, e_new);
        check("dsp_din1_re", dsp_din1_re, e_d[0]);
        check("dsp_din1_im", dsp_din1_im, e_d[1]);
        check("dsp_din2_re", dsp_din2_re, e_d[2]);
        check("dsp_din2_im", dsp_din2_im, e_d[3]);
        check("shift", shift, e_shift);
        check("res_valid", res_valid, e_rv);
        check("res_lamb1", res_lamb1, e_res[0]);
        check("res_lamb2", res_lamb2, e_res[1]);
        check("res_eigen1_y", res_eigen1_y, e_res[2]);
        check("res_eigen2_y", res_eigen2_y, e_res[3]);
        check("res_eigen_x", res_eigen_x, e_res[4]);
        check("res_tag", res_tag, e_tag);
        check("overrun_cnt", overrun_cnt, e_ovr);
        check("sync_err", sync_err, e_serr);
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    // Reset is applied between edges so its asynchronous effect is visible
    // before any clock arrives.
    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        #2;
        compare_all();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic drive_sample(input bit sy);
        din_valid = 1; sync_in = sy;
        din1_re = 18'($urandom); din1_im = 18'($urandom);
        din2_re = 18'($urandom); din2_im = 18'($urandom);
    endtask

    task automatic idle_in();
        din_valid = 0; sync_in = 0;
    endtask

    task automatic run_integ(input bit sy, input int a, input int b);
        for (int k = 0; k < VL; k++) begin
            drive_sample(sy && k == 0);
            corr_valid = (k == 3);
            r11 = 16'(a); r22 = 16'(b);
            tick();
        end
        corr_valid = 0;
    endtask

    task automatic drive_result();
        dout_valid = 1;
        lamb1 = 16'($urandom); lamb2 = 16'($urandom); eigen1_y = 16'($urandom);
        eigen2_y = 16'($urandom); eigen_x = 16'($urandom);
    endtask

    int          pos_q[$];
    logic [15:0] first_l1;

    initial begin
        enable = 0; agc_en = 1; sync_in = 0; din_valid = 0; corr_valid = 0;
        dout_valid = 0; res_ready = 0; acc_len = 8'd2; shift_manual = 5'd0;
        thr_hi = 16'h7FFF; thr_lo = 16'h0000;
        din1_re = 0; din1_im = 0; din2_re = 0; din2_im = 0; r11 = 0; r22 = 0;
        lamb1 = 0; lamb2 = 0; eigen1_y = 0; eigen2_y = 0; eigen_x = 0;
        #1;
        do_reset();

        // acc_len = 2: strobes at forwarded samples 0 and 16 of 32
        enable = 1; idle_in(); tick();
        for (int k = 0; k < 32; k++) begin
            drive_sample(k == 0); tick();
            if (dsp_new_acc) pos_q.push_back(k);
        end
        idle_in(); tick();
        check("acc2_strobe_count", pos_q.size(), 2);
        if (pos_q.size() == 2) begin
            check("acc2_strobe_a", pos_q[0], 0);
            check("acc2_strobe_b", pos_q[1], 16);
        end

        // acc_len = 0 behaves as 1: strobe every 8th sample
        enable = 0; tick(); enable = 1; acc_len = 8'd0; tick();
        pos_q.delete();
        for (int k = 0; k < 24; k++) begin
            drive_sample(k == 0); tick();
            if (dsp_new_acc) pos_q.push_back(k);
        end
        idle_in(); tick();
        check("acc0_strobe_count", pos_q.size(), 3);
        foreach (pos_q[i]) check("acc0_strobe_pos", pos_q[i], i * 8);

        // misaligned sync at channel 3
        enable = 0; tick(); enable = 1; tick();
        for (int k = 0; k < 3; k++) begin drive_sample(k == 0); tick(); end
        drive_sample(1); tick();
        check("serr_flag", sync_err, 1);
        check("serr_state_arm", fsm_state, 1);
        check("serr_dropped", dsp_din_valid, 0);
        pos_q.delete();
        for (int k = 0; k < 5; k++) begin
            drive_sample(0); tick();
            if (dsp_new_acc) pos_q.push_back(k);
        end
        check("serr_no_strobe", pos_q.size(), 0);
        drive_sample(1); tick();
        check("serr_resync_strobe", dsp_new_acc, 1);
        for (int k = 1; k < VL; k++) begin drive_sample(0); tick(); end
        idle_in(); tick();

        // AGC sequence from a fresh reset (shift = 8)
        do_reset();
        thr_hi = 16'h4000; thr_lo = 16'h1000; agc_en = 1; acc_len = 8'd1;
        enable = 1; idle_in(); tick();
        run_integ(1, 'h5000, 0);  check("agc_unseen_hold", shift, 8);
        run_integ(0, 'h0800, 0);  check("agc_up", shift, 9);
        run_integ(0, 'h2000, 0);  check("agc_down", shift, 8);
        thr_lo = 16'h0200;
        run_integ(0, -5, 'h0100); check("agc_hold", shift, 8);
        run_integ(0, 'h5000, 0);  check("agc_neg_clamp_down", shift, 7);
        agc_en = 0; shift_manual = 5'd3;
        run_integ(0, 'h5000, 0);  check("agc_manual3", shift, 3);
        shift_manual = 5'd30;
        run_integ(0, 'h5000, 0);  check("agc_manual30", shift, 30);
        agc_en = 1;
        run_integ(0, 'h5000, 0);  check("agc_to_max", shift, 31);
        run_integ(0, 'h5000, 0);  check("agc_max_clamp", shift, 31);
        idle_in(); tick();

        // result capture with overruns
        res_ready = 0;
        drive_result(); first_l1 = lamb1; tick();
        dout_valid = 0; tick();
        drive_result(); tick();
        drive_result(); tick();
        dout_valid = 0; tick();
        check("cap_held_lamb1", res_lamb1, first_l1);
        check("cap_overrun", overrun_cnt, 2);
        check("cap_valid_held", res_valid, 1);
        res_ready = 1; drive_result(); first_l1 = lamb1; tick();
        check("cap_reload_lamb1", res_lamb1, first_l1);
        check("cap_reload_valid", res_valid, 1);
        dout_valid = 0; tick();
        check("cap_drained", res_valid, 0);

        // randomized soak with a mid-run reset
        for (int n = 0; n < 1600; n++) begin
            if (n == 900) do_reset();
            enable = ($urandom_range(0, 199) != 0);
            din_valid = ($urandom_range(0, 3) != 0);
            din1_re = 18'($urandom); din1_im = 18'($urandom);
            din2_re = 18'($urandom); din2_im = 18'($urandom);
            sync_in = din_valid && (((m_mode == 1) && $urandom_range(0, 2) == 0) ||
                                    ((m_mode == 2) && (m_pos % VL) == 0 && $urandom_range(0, 1) == 0) ||
                                    ($urandom_range(0, 39) == 0));
            if ($urandom_range(0, 49) == 0) acc_len = 8'($urandom_range(0, 3));
            if ($urandom_range(0, 99) == 0) agc_en = ~agc_en;
            shift_manual = 5'($urandom);
            thr_hi = 16'($urandom_range(16'h2000, 16'h7000));
            thr_lo = 16'($urandom_range(0, 16'h3000));
            corr_valid = ($urandom_range(0, 3) == 0);
            r11 = 16'($urandom); r22 = 16'($urandom);
            dout_valid = 0;
            if ($urandom_range(0, 5) == 0) drive_result();
            res_ready = ($urandom_range(0, 1) == 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
